// File: rtl/q294_share_ctrl.sv
// q294_share_ctrl
//   Wraps a 3-share Q294 masked sbox stage. It accepts one unmasked nibble,
//   splits it into three Boolean shares using fresh LFSR randomness, and
//   drives those shares for one cycle. It then captures the registered
//   output shares returned by the stage, presents the recombined result and
//   holds it until the consumer accepts it.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_seed_load, i_seed       reseed the randomness LFSR (IDLE, no input offered)
//   i_in_valid, o_in_ready,   unmasked input nibble handshake
//   i_in_data
//   o_s_in1..3, o_s_r         shares and refresh bits to the Q294 stage
//   i_s_out1..3               shares returned by the stage (1-cycle latency)
//   o_out_valid, i_out_ready, result handshake; o_out_data is the recombined
//   o_out_data, o_out_sh1..3  value, o_out_sh* the raw captured shares
module q294_share_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_seed_load,
  input  logic [31:0] i_seed,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [3:0]  i_in_data,
  output logic [3:0]  o_s_in1,
  output logic [3:0]  o_s_in2,
  output logic [3:0]  o_s_in3,
  output logic [12:0] o_s_r,
  input  logic [3:0]  i_s_out1,
  input  logic [3:0]  i_s_out2,
  input  logic [3:0]  i_s_out3,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [3:0]  o_out_data,
  output logic [3:0]  o_out_sh1,
  output logic [3:0]  o_out_sh2,
  output logic [3:0]  o_out_sh3
);

  localparam logic [31:0] LFSR_RST  = 32'hACE1_2468;
  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_lfsr;
  logic        r_in_ready;
  logic [3:0]  r_s_in1, r_s_in2, r_s_in3;
  logic [12:0] r_s_r;
  logic        r_out_valid;
  logic [3:0]  r_out_data, r_out_sh1, r_out_sh2, r_out_sh3;

  logic [31:0] w_lfsr_next;
  logic [3:0]  w_m1, w_m2, w_s_in3;
  logic [12:0] w_rr;

  // 32 single Galois steps flattened into one combinational draw
  function automatic logic [31:0] f_lfsr_adv32(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int k = 0; k < 32; k++)
      v = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    return v;
  endfunction

  assign w_lfsr_next = f_lfsr_adv32(r_lfsr);
  assign w_m1        = w_lfsr_next[3:0];
  assign w_m2        = w_lfsr_next[7:4];
  assign w_rr        = w_lfsr_next[20:8];
  // The only point where the unmasked nibble meets mask material. Masking
  // it with m1 first and registering the result keeps the stage inputs
  // glitch-free and means the raw nibble is never stored.
  assign w_s_in3     = (i_in_data ^ w_m1) ^ w_m2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_RST;
      r_in_ready  <= 1'b1;
      r_s_in1     <= '0;
      r_s_in2     <= '0;
      r_s_in3     <= '0;
      r_s_r       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sh1   <= '0;
      r_out_sh2   <= '0;
      r_out_sh3   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            // an offered input wins over a same-cycle reseed
            r_lfsr     <= w_lfsr_next;
            r_s_in1    <= w_m1;
            r_s_in2    <= w_m2;
            r_s_in3    <= w_s_in3;
            r_s_r      <= w_rr;
            r_in_ready <= 1'b0;
            r_state    <= S_ISSUE;
          end else if (i_seed_load) begin
            // all-zero is the Galois lock-up state
            r_lfsr <= (i_seed == 32'd0) ? 32'h0000_0001 : i_seed;
          end
        end
        S_ISSUE: begin
          r_s_in1 <= '0;
          r_s_in2 <= '0;
          r_s_in3 <= '0;
          r_s_r   <= '0;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // stage outputs now reflect the shares issued last cycle
          r_out_sh1   <= i_s_out1;
          r_out_sh2   <= i_s_out2;
          r_out_sh3   <= i_s_out3;
          r_out_data  <= i_s_out1 ^ i_s_out2 ^ i_s_out3;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_s_in1     = r_s_in1;
  assign o_s_in2     = r_s_in2;
  assign o_s_in3     = r_s_in3;
  assign o_s_r       = r_s_r;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sh1   = r_out_sh1;
  assign o_out_sh2   = r_out_sh2;
  assign o_out_sh3   = r_out_sh3;

endmodule

// File: tb/tb_q294_share_ctrl.sv
// Self-checking bench for q294_share_ctrl. A 3-share Q294 stage model
// (threshold-implementation AND terms, registered) is attached to the share
// ports. A transaction-level model predicts every output on every falling
// edge; a few literal expectations pin that model.
module tb_q294_share_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic [3:0]  s_in1, s_in2, s_in3;
  logic [12:0] s_r;
  logic [3:0]  s_out1 = '0, s_out2 = '0, s_out3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_data, out_sh1, out_sh2, out_sh3;

  q294_share_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_seed_load(seed_load), .i_seed(seed),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_s_in1(s_in1), .o_s_in2(s_in2), .o_s_in3(s_in3), .o_s_r(s_r),
    .i_s_out1(s_out1), .i_s_out2(s_out2), .i_s_out3(s_out3),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_sh1(out_sh1), .o_out_sh2(out_sh2), .o_out_sh3(out_sh3)
  );

  always #5 clk = ~clk;

  // Q294 function: y[3:2]=x[3:2], y1=x1^(x3&x2), y0=x0^(x2&x1)
  localparam logic [3:0] GOLD [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h6,
                                       4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF, 4'hD, 4'hC};

  // one output share from the two other input shares p, q
  function automatic logic [3:0] stage_sh(input logic [3:0] p, input logic [3:0] q);
    logic [3:0] y;
    y[3:2] = p[3:2];
    y[1]   = p[1] ^ (p[3] & p[2]) ^ (p[3] & q[2]) ^ (q[3] & p[2]);
    y[0]   = p[0] ^ (p[2] & p[1]) ^ (p[2] & q[1]) ^ (q[2] & p[1]);
    return y;
  endfunction

  always @(posedge clk) begin
    s_out1 <= stage_sh(s_in2, s_in3);
    s_out2 <= stage_sh(s_in3, s_in1);
    s_out3 <= stage_sh(s_in1, s_in2);
  end

  // randomness draw: 32 Galois steps of x^32+x^22+x^2+x+1
  function automatic logic [31:0] draw(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int k = 0; k < 32; k++) begin
      if (v[0]) v = (v >> 1) ^ 32'h8020_0003;
      else      v = v >> 1;
    end
    return v;
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: phase = cycles since accept (0 = waiting, 3 = holding)
  int          m_phase;
  logic [31:0] m_lfsr;
  logic [3:0]  m_x;
  logic [3:0]  m_data;
  logic        m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_lfsr  <= 32'hACE1_2468;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_lfsr  <= draw(m_lfsr);
             m_x     <= in_data;
             m_phase <= 1;
           end else if (seed_load) begin
             m_lfsr <= (seed == 32'd0) ? 32'd1 : seed;
           end
        1: m_phase <= 2;
        2: begin m_data <= GOLD[m_x]; m_valid <= 1'b1; m_phase <= 3; end
        default: if (out_ready) begin m_valid <= 1'b0; m_phase <= 0; end
      endcase
    end
  end

  bit          chk_en = 1'b0;
  logic [24:0] trace [$];

  always @(negedge clk) begin
    if (chk_en) begin
      logic       iss;
      logic [3:0] m1, m2;
      iss = (m_phase == 1);
      m1  = m_lfsr[3:0];
      m2  = m_lfsr[7:4];
      chk("s_in1", 32'(s_in1), iss ? 32'(m1) : 32'd0);
      chk("s_in2", 32'(s_in2), iss ? 32'(m2) : 32'd0);
      chk("s_in3", 32'(s_in3), iss ? 32'(m_x ^ m1 ^ m2) : 32'd0);
      chk("s_r",   32'(s_r),   iss ? 32'(m_lfsr[20:8]) : 32'd0);
      if (iss) begin
        chk("share_sum", 32'(s_in1 ^ s_in2 ^ s_in3), 32'(m_x));
        trace.push_back({s_in1, s_in2, s_in3, s_r});
      end
      if (!rst) chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("out_sh_sum", 32'(out_sh1 ^ out_sh2 ^ out_sh3), 32'(m_data));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // full transaction, consumer ready from the first HOLD cycle
  task automatic send(input logic [3:0] d);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    chk("sweep_gold", 32'(out_data), 32'(GOLD[d]));
    tick(1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
  endtask

  task automatic run_stream(input logic [31:0] sd, output logic [24:0] tr [4]);
    reset_pulse();
    seed_load = 1'b1; seed = sd; tick(1); seed_load = 1'b0;
    trace.delete();
    send(4'h3); send(4'hA); send(4'h6); send(4'hF);
    for (int i = 0; i < 4; i++) tr[i] = (trace.size() > i) ? trace[i] : 25'd0;
  endtask

  initial begin
    logic [31:0] exp_l;
    logic [24:0] tA [4];
    logic [24:0] tB [4];
    logic [24:0] tC [4];
    bit          same_ab, same_ac;

    #1 rst = 1'b1;
    chk_en = 1'b1;
    tick(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s_in", 32'({s_in1, s_in2, s_in3, s_r}), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // nibble C: shares recombine to C, result E with top bits 11
    in_valid = 1'b1; in_data = 4'hC;
    tick(1);
    in_valid = 1'b0;
    chk("c_share_sum", 32'(s_in1 ^ s_in2 ^ s_in3), 32'hC);
    exp_l = draw(32'hACE1_2468);
    chk("c_first_mask", 32'(s_in1), 32'(exp_l[3:0]));
    tick(1);
    chk("c_shares_cleared", 32'({s_in1, s_in2, s_in3}), 32'd0);
    tick(1);
    chk("c_out_valid", 32'(out_valid), 32'd1);
    chk("c_out_data", 32'(out_data), 32'hE);
    chk("c_out_top", 32'(out_data[3:2]), 32'd3);
    tick(1);

    for (int i = 0; i < 16; i++) send(4'(i));

    // stalled consumer with in_valid held high
    in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b0;
    tick(13);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(out_data), 32'h6);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(2);

    // zero seed becomes 1
    seed_load = 1'b1; seed = 32'd0; tick(1); seed_load = 1'b0;
    in_valid = 1'b1; in_data = 4'h3; tick(1); in_valid = 1'b0;
    exp_l = draw(32'd1);
    chk("seed0_m1", 32'(s_in1), 32'(exp_l[3:0]));
    chk("seed0_rr", 32'(s_r), 32'(exp_l[20:8]));
    tick(3);

    // reseed during HOLD is ignored (model keeps the drawn state)
    in_valid = 1'b1; in_data = 4'h9; out_ready = 1'b0; tick(1); in_valid = 1'b0;
    tick(2);
    seed_load = 1'b1; seed = 32'hDEAD_BEEF; tick(2); seed_load = 1'b0;
    out_ready = 1'b1; tick(1);
    send(4'h1);

    // reset while capturing abandons the transaction
    in_valid = 1'b1; in_data = 4'hA; tick(1); in_valid = 1'b0;
    tick(1);
    rst = 1'b1; #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_shares", 32'({s_in1, s_in2, s_in3, s_r}), 32'd0);
    chk("midrst_out", 32'({out_data, out_sh1, out_sh2, out_sh3}), 32'd0);
    tick(1); rst = 1'b0;
    tick(5);
    chk("midrst_no_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 4'h2; tick(1); in_valid = 1'b0;
    exp_l = draw(32'hACE1_2468);
    chk("midrst_base_m2", 32'(s_in2), 32'(exp_l[7:4]));
    tick(3);

    // repeatability and seed sensitivity of the mask stream
    run_stream(32'h1234_5678, tA);
    run_stream(32'h1234_5678, tB);
    run_stream(32'h8765_4321, tC);
    same_ab = 1'b1; same_ac = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (tA[i] !== tB[i]) same_ab = 1'b0;
      if (tA[i] !== tC[i]) same_ac = 1'b0;
    end
    chk("trace_repeat", 32'(same_ab), 32'd1);
    chk("trace_seed_diff", 32'(same_ac), 32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/q294_share_ctrl.md
Q294_SHARE_CTRL -- requirements
Module: q294_share_ctrl

Interface
REQ-001 clk  input  1  single clock for all sequential logic; all state updates on posedge clk.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 seed_load  input  1  request to load seed into the randomness LFSR.
REQ-004 seed  input  32  LFSR seed value.
REQ-005 in_valid  input  1  unmasked nibble offered.
REQ-006 in_ready  output  1  block accepts a nibble this cycle.
REQ-007 in_data  input  4  unmasked 4-bit sbox-stage input.
REQ-008 s_in1, s_in2, s_in3  output  4 each  share 0/1/2 driven to the 3-share Q294 stage.
REQ-009 s_r  output  13  fresh refresh bits driven to the Q294 stage.
REQ-010 s_out1, s_out2, s_out3  input  4 each  share 0/1/2 returned by the Q294 stage (registered there, 1-cycle latency).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  4  unmasked result = s_out1^s_out2^s_out3 as captured.
REQ-014 out_sh1, out_sh2, out_sh3  output  4 each  captured output shares for chained masked use.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, CAPTURE, HOLD; encoding free.
REQ-016 IDLE: in_ready=1; in_valid=1 -> latch in_data, draw randomness, go ISSUE.
REQ-017 ISSUE (exactly 1 cycle): s_in1=m1, s_in2=m2, s_in3=in_data^m1^m2, s_r=rr, all from registers, stable the whole cycle; go CAPTURE.
REQ-018 CAPTURE (exactly 1 cycle): shares and s_r SHALL return to 0; sample s_out1..3 into out_sh1..3 and out_data at end of cycle; go HOLD.
REQ-019 HOLD: out_valid=1; out_data/out_sh* stable; out_ready=1 -> IDLE next cycle; otherwise stay.
REQ-020 in_ready SHALL be 0 in ISSUE, CAPTURE, HOLD; minimum 4 cycles accept-to-accept, 3 cycles accept-to-out_valid.
REQ-021 s_in1..3 and s_r SHALL be 0 in every state except ISSUE.
REQ-022 Randomness: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1; a draw advances it 32 single steps (unrolled, one clock); m1=state[3:0], m2=state[7:4], rr=state[20:8] of the post-advance state.
REQ-023 LFSR SHALL advance only on an accepted input; never otherwise.
REQ-024 seed_load honoured only in IDLE and with in_valid=0; ignored in other states or if in_valid=1 same cycle (input wins).
REQ-025 seed of 0 SHALL load 32'h0000_0001 instead (no lock-up state).
REQ-026 No unmasked value (in_data, out_data) SHALL be combined with shares in any path feeding s_in*/s_r except the single s_in3 XOR of REQ-017.
REQ-027 out_data/out_sh* SHALL hold last captured values in IDLE (out_valid=0).

Reset
REQ-028 rst=1: FSM->IDLE, LFSR=32'hACE1_2468, all outputs 0 except in_ready=1 once out of reset; effect immediate.
REQ-029 Reset mid-operation (ISSUE/CAPTURE/HOLD) SHALL abandon the transaction; no out_valid pulse after deassert.

Verification
REQ-030 Reset, in_data=4'hC, out_ready=1 -> s_in* nonzero only in cycle 1 after accept, s_in1^s_in2^s_in3=4'hC, out_valid in cycle 3, out_data[3:2]=2'b11, out_data[1:0] = team Q294 golden table.
REQ-031 Sweep all 16 in_data with Q294 stage attached -> out_data[3:2]=in_data[3:2], out_data[1:0] matches golden table, out_sh1^out_sh2^out_sh3=out_data.
REQ-032 Hold out_ready=0 for 10 cycles with in_valid=1 -> out_valid and out_data stable, in_ready=0, LFSR unchanged, no second accept.
REQ-033 seed_load with seed=0 in IDLE, then accept -> LFSR advanced from 32'h1 by 32 steps; seed_load during HOLD -> ignored.
REQ-034 Assert rst during CAPTURE -> outputs 0 immediately, no out_valid after release, next accept uses LFSR=32'hACE1_2468 as base.
REQ-035 Two resets with same seed and same input stream -> bit-identical s_in*/s_r traces; different seeds -> different masks.
